// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: operation and state
// encodings plus operand signedness decoding.
package muldiv_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic src_a_signed(input op_e op);
    return !(op inside {OP_MULHU, OP_DIVU, OP_REMU});
  endfunction

  function automatic logic src_b_signed(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-divide iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if non-negative.
module muldiv_divstep #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = {rem_in, quo_in[W-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[W]) begin
      rem_out = diff[W-1:0];
      quo_out = {quo_in[W-2:0], 1'b1};
    end else begin
      rem_out = shifted[W-1:0];
      quo_out = {quo_in[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per cycle on magnitudes, sign correction applied when the result is presented.
//
// state | meaning
// IDLE  | ready to accept a request
// BUSY  | iterating, one step per cycle, counter runs DATA_WIDTH-1 down to 0
// DONE  | result presented, held until out_ready
module alu_muldiv
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int OPCODE_LENGTH = 3,
  parameter int TAG_WIDTH     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    SrcA,
  input  logic [DATA_WIDTH-1:0]    SrcB,
  input  logic [OPCODE_LENGTH-1:0] Operation,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    ALUResult,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic                     busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  state_e            state_q, state_d;
  op_e               op_q, op_in;
  logic [2*W-1:0]    acc_q, acc_step, acc_init;
  logic [W-1:0]      opnd_q, opnd_init;
  logic [CW-1:0]     cnt_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic              neg_hi_q, neg_lo_q;
  logic              accept;
  logic              a_neg, b_neg;
  logic [W-1:0]      a_mag, b_mag;
  logic [W-1:0]      mul_add;
  logic [W:0]        mul_sum;
  logic [W-1:0]      div_rem, div_quo;
  logic [2*W-1:0]    prod;
  logic [W-1:0]      quo, rem, result;

  assign op_in     = op_e'(Operation[OP_W-1:0]);
  assign in_ready  = (state_q == ST_IDLE) && !flush;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_tag   = tag_q;
  assign ALUResult = out_valid ? result : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == '0) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Multiply keeps the multiplier in the low half of acc; divide keeps the
  // dividend there and the partial remainder in the high half.
  always_comb begin
    a_neg = src_a_signed(op_in) && SrcA[W-1];
    b_neg = src_b_signed(op_in) && SrcB[W-1];
    a_mag = a_neg ? -SrcA : SrcA;
    b_mag = b_neg ? -SrcB : SrcB;
    if (op_is_div(op_in)) begin
      acc_init  = {{W{1'b0}}, a_mag};
      opnd_init = b_mag;
    end else begin
      acc_init  = {{W{1'b0}}, b_mag};
      opnd_init = a_mag;
    end
  end

  muldiv_divstep #(.W(W)) u_divstep (
    .rem_in  (acc_q[2*W-1:W]),
    .quo_in  (acc_q[W-1:0]),
    .divisor (opnd_q),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  always_comb begin
    mul_add  = acc_q[0] ? opnd_q : '0;
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_add};
    acc_step = op_is_div(op_q) ? {div_rem, div_quo} : {mul_sum, acc_q[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      tag_q    <= '0;
      op_q     <= OP_MUL;
      neg_hi_q <= 1'b0;
      neg_lo_q <= 1'b0;
    end else if (accept) begin
      acc_q    <= acc_init;
      opnd_q   <= opnd_init;
      cnt_q    <= CW'(W - 1);
      tag_q    <= in_tag;
      op_q     <= op_in;
      neg_hi_q <= a_neg ^ b_neg;
      neg_lo_q <= a_neg;
    end else if (state_q == ST_BUSY && !flush) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // A zero divisor leaves the remainder equal to the dividend naturally;
  // only the quotient needs forcing to all ones.
  always_comb begin
    prod = neg_hi_q ? -acc_q : acc_q;
    quo  = neg_hi_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem  = neg_lo_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    unique case (op_q)
      OP_MUL:                      result = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod[2*W-1:W];
      OP_DIV, OP_DIVU:             result = (opnd_q == '0) ? '1 : quo;
      default:                     result = rem;
    endcase
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv: driver pushes expected results into a
// queue, a negedge monitor pops and compares whenever a result is handed off.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  Operation;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic [4:0]  out_tag;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   mon_on = 1'b0;
  logic prev_valid = 1'b0;

  alu_muldiv #(.DATA_WIDTH(32), .OPCODE_LENGTH(3), .TAG_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
    .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .ALUResult(ALUResult), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency on rising out_valid, value/tag on handoff, zero result otherwise.
  always @(negedge clk) begin
    if (mon_on) begin
      if (out_valid === 1'b1 && prev_valid !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got %0h tag %0h expected none", ALUResult, out_tag);
        end else begin
          // accept edge counted as edge 1, so out_valid follows edge acc+32
          chk("latency", 64'(cycle - sb[0].acc), 64'd32);
        end
      end
      if (out_valid !== 1'b1) chk("idle_result_zero", ALUResult, 0);
      if (out_valid === 1'b1 && out_ready === 1'b1 && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("result", ALUResult, e.res);
        chk("tag", out_tag, e.tag);
      end
      prev_valid = out_valid;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp, input bit expect_out);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready %b expected 1", in_ready);
      return;
    end
    in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b; in_tag = tag;
    @(posedge clk); #1;
    if (expect_out) sb.push_back('{exp, tag, cycle});
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy === 1'b1) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending %0d busy %b expected 0 0", sb.size(), busy);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_res;
    logic [4:0]  held_tag;
    int n;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    SrcA = '0; SrcB = '0; Operation = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", ALUResult, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    mon_on = 1'b1;

    // op, a, b, tag, expected
    issue(3'b000, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 1); drain();
    issue(3'b001, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 1); drain();
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 1); drain();
    issue(3'b010, 32'hFFFFFFFF, 32'd2,        5'd4,  32'hFFFFFFFF, 1); drain();
    issue(3'b100, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 1); drain();
    issue(3'b110, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 1); drain();
    issue(3'b101, 32'd100,      32'd7,        5'd7,  32'd14,       1); drain();
    issue(3'b111, 32'd100,      32'd7,        5'd8,  32'd2,        1); drain();
    issue(3'b101, 32'h1234,     32'd0,        5'd10, 32'hFFFFFFFF, 1); drain();
    issue(3'b111, 32'h1234,     32'd0,        5'd11, 32'h1234,     1); drain();
    issue(3'b100, 32'hFFFFFFF9, 32'd0,        5'd12, 32'hFFFFFFFF, 1); drain();
    issue(3'b110, 32'hFFFFFFF9, 32'd0,        5'd13, 32'hFFFFFFF9, 1); drain();
    issue(3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1); drain();
    issue(3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0,        1); drain();

    // Backpressure: hold the result for 10 cycles while offering another request.
    out_ready = 1'b0;
    issue(3'b000, 32'd6, 32'd7, 5'd20, 32'd42, 1);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", out_valid, 1);
    held_res = ALUResult;
    held_tag = out_tag;
    chk("bp_held_value", held_res, 32'd42);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; Operation = 3'b000; SrcA = 32'd5; SrcB = 32'd5; in_tag = 5'd21;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result_stable", ALUResult, held_res);
      chk("bp_tag_stable", out_tag, held_tag);
      chk("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_busy", busy, 0);
    drain();

    // Flush in the fifth BUSY cycle; the squashed op must never appear.
    issue(3'b000, 32'd11, 32'd13, 5'd22, 32'd0, 0);
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    chk("flush_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_out_valid", out_valid, 0);
    issue(3'b000, 32'd3, 32'd4, 5'd9, 32'd12, 1);
    drain();

    // Reset during BUSY discards the operation.
    issue(3'b101, 32'd1000, 32'd3, 5'd23, 32'd0, 0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rstb_out_valid", out_valid, 0);
    chk("rstb_result", ALUResult, 0);
    chk("rstb_tag", out_tag, 0);
    chk("rstb_busy", busy, 0);
    chk("rstb_in_ready", in_ready, 1);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("rstb_no_stale", out_valid, 0);

    issue(3'b011, 32'h00010000, 32'h00010000, 5'd24, 32'd1, 1);
    drain();

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_left: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: DATA_WIDTH, 32, operand/result width (even, >=8).
REQ-002 Parameter: OPCODE_LENGTH, 3, operation field width (RV32M funct3).
REQ-003 Parameter: TAG_WIDTH, 5, destination-register tag width carried with each operation.
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-006 Port: flush  in  1  abort in-flight or pending operation (pipeline squash).
REQ-007 Port: in_valid  in  1  request present; in_ready  out  1  unit can accept.
REQ-008 Port: SrcA, SrcB  in  DATA_WIDTH  operands (SrcA = multiplicand/dividend).
REQ-009 Port: Operation  in  OPCODE_LENGTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-010 Port: in_tag  in  TAG_WIDTH  tag captured on accept.
REQ-011 Port: out_valid  out  1  result present; out_ready  in  1  consumer takes result.
REQ-012 Port: ALUResult  out  DATA_WIDTH  result; out_tag  out  TAG_WIDTH  captured tag.
REQ-013 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-014 States: IDLE, BUSY, DONE; in_ready = (state == IDLE) and not flush.
REQ-015 Accept when in_valid && in_ready at a rising edge: capture operands (converted to magnitudes per signedness), op, tag, sign flags; counter = DATA_WIDTH-1; go BUSY.
REQ-016 Signedness: MUL/MULH/DIV/REM both signed; MULHSU SrcA signed, SrcB unsigned; MULHU/DIVU/REMU unsigned.
REQ-017 BUSY performs exactly one iteration per cycle: shift-add multiply (2*DATA_WIDTH-bit product) or restoring divide step; counter decrements; at counter == 0 the edge moves to DONE.
REQ-018 Latency fixed and op-independent: out_valid rises in the cycle after the (DATA_WIDTH+1)-th rising edge counting the accept edge as the first, i.e. 33 cycles for DATA_WIDTH=32.
REQ-019 In DONE: out_valid = 1; ALUResult and out_tag held stable until out_valid && out_ready edge, which returns to IDLE; no new accept in that same cycle.
REQ-020 Results: MUL low half; MULH/MULHSU/MULHU high half of sign-corrected 2*DATA_WIDTH product; DIV/DIVU quotient truncated toward zero; REM/REMU remainder with sign of dividend.
REQ-021 Divide by zero: quotient = all ones, remainder = SrcA; same latency.
REQ-022 Signed overflow (SrcA = most negative, SrcB = -1, DIV/REM): quotient = SrcA, remainder = 0; same latency.
REQ-023 flush in any state: next state IDLE, out_valid low next cycle, result discarded; flush has priority over accept and over out_ready.
REQ-024 ALUResult is 0 whenever out_valid is low.

Reset
REQ-025 On rising edge with rst_n low: state IDLE, counter 0, datapath registers 0; out_valid 0, ALUResult 0, out_tag 0, busy 0, in_ready 1 from the following cycle.
REQ-026 Reset during BUSY or DONE discards the operation; no result is ever presented for it.

Structure
REQ-027 Package muldiv_pkg holds the operation enum (OPCODE_LENGTH bits), the state enum, and helper constants for signedness decoding.
REQ-028 One combinational sub-module, muldiv_divstep, implements a single restoring-divide iteration (remainder, quotient in; remainder, quotient out); the multiply step stays inline.

Verification
REQ-029 MUL 7 x 0xFFFFFFFD -> ALUResult 0xFFFFFFEB, out_valid exactly 33 cycles after accept; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-030 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14, REMU -> 2.
REQ-031 DIVU 0x1234 / 0 -> 0xFFFFFFFF; REMU 0x1234 / 0 -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 Backpressure: out_ready low 10 cycles after out_valid -> ALUResult/out_tag stable, in_ready low, in_valid ignored; out_ready high -> IDLE next cycle, in_ready high.
REQ-033 flush at BUSY cycle 5 -> no out_valid ever for that op; next request (MUL 3 x 4, tag 9) returns 12 with out_tag 9 at nominal latency.
REQ-034 rst_n low for one edge during BUSY -> all outputs zero, in_ready high next cycle, no stale result emitted.
